// File: rtl/slice_adder_sequencer_if.sv
// Signal bundle between an operand producer/consumer, the slice adder sequencer and a shared narrow adder.
// Port sub exists only when SLICE_ADDER_SUB_EN is defined.
interface slice_adder_sequencer_if #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
`ifdef SLICE_ADDER_SUB_EN
   logic             sub;
`endif
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic             slice_cin;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             busy;

   // Sequencer side: consumes requests and adder results, produces slices and responses.
   modport slave (
`ifdef SLICE_ADDER_SUB_EN
      input  sub,
`endif
      input  start_valid,
      input  a,
      input  b,
      input  c_in,
      input  slice_sum,
      input  slice_cout,
      input  done_ready,
      output start_ready,
      output slice_a,
      output slice_b,
      output slice_cin,
      output done_valid,
      output sum,
      output c_out,
      output busy
   );

   // Environment side: operand producer, result consumer and the external slice adder.
   modport master (
`ifdef SLICE_ADDER_SUB_EN
      output sub,
`endif
      output start_valid,
      output a,
      output b,
      output c_in,
      output slice_sum,
      output slice_cout,
      output done_ready,
      input  start_ready,
      input  slice_a,
      input  slice_b,
      input  slice_cin,
      input  done_valid,
      input  sum,
      input  c_out,
      input  busy
   );
endinterface

// File: rtl/slice_adder_sequencer.sv
// Time-multiplexes one external SLICE-bit adder over WIDTH/SLICE cycles to form a WIDTH-bit sum, LS slice first.
// Define SLICE_ADDER_SUB_EN to add the sub request input (a - b via inverted b and forced carry-in).
module slice_adder_sequencer #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   slice_adder_sequencer_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             c_out_q, c_out_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] b_capture;
   logic             carry_capture;

   logic [SLICE-1:0] a_slices [NSLICE];
   logic [SLICE-1:0] b_slices [NSLICE];

   genvar gi;
   generate
      for (gi = 0; gi < NSLICE; gi++) begin : g_slice
         assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
         assign b_slices[gi] = b_q[gi*SLICE +: SLICE];
      end
   endgenerate

`ifdef SLICE_ADDER_SUB_EN
   // Subtraction reuses the adder: a + ~b + 1, so c_out=1 means no borrow.
   assign b_capture     = bus.sub ? ~bus.b : bus.b;
   assign carry_capture = bus.sub ? 1'b1 : bus.c_in;
`else
   assign b_capture     = bus.b;
   assign carry_capture = bus.c_in;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               a_d     = bus.a;
               b_d     = b_capture;
               carry_d = carry_capture;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int i = 0; i < NSLICE; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[i*SLICE +: SLICE] = bus.slice_sum;
               end
            end
            carry_d = bus.slice_cout;
            if (cnt_q == LAST_CNT) begin
               c_out_d = bus.slice_cout;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            // Result stays frozen until the consumer takes it; no re-accept this cycle.
            if (bus.done_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         cnt_q   <= cnt_d;
      end
   end

   // The shared adder sees zeros whenever this sequencer is not using it.
   assign bus.slice_a     = (state_q == S_RUN) ? a_slices[cnt_q] : '0;
   assign bus.slice_b     = (state_q == S_RUN) ? b_slices[cnt_q] : '0;
   assign bus.slice_cin   = (state_q == S_RUN) ? carry_q : 1'b0;

   assign bus.start_ready = (state_q == S_IDLE);
   assign bus.done_valid  = (state_q == S_DONE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.sum         = sum_q;
   assign bus.c_out       = c_out_q;
endmodule

// File: tb/tb_slice_adder_sequencer.sv
// Directed and random checks of slice_adder_sequencer with a behavioural 16-bit slice adder in the loop.
// Subtraction scenario runs only when SLICE_ADDER_SUB_EN is defined.
module tb_slice_adder_sequencer;
   localparam int WIDTH  = 64;
   localparam int SLICE  = 16;
   localparam int NSLICE = WIDTH / SLICE;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   slice_adder_sequencer_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

   slice_adder_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // The shared narrow adder the sequencer drives.
   assign {bus.slice_cout, bus.slice_sum} = {1'b0, bus.slice_a} + {1'b0, bus.slice_b}
                                            + {{SLICE{1'b0}}, bus.slice_cin};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.start_valid = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      bus.c_in        = 1'b0;
      bus.done_ready  = 1'b0;
`ifdef SLICE_ADDER_SUB_EN
      bus.sub         = 1'b0;
`endif
   endtask

   task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
      int guard = 0;
      while (bus.start_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: start_ready=%b, expected 1 within 20 cycles", bus.start_ready);
      end
      bus.start_valid = 1'b1;
      bus.a           = av;
      bus.b           = bv;
      bus.c_in        = cv;
      tick();
      bus.start_valid = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (bus.done_valid !== 1'b1 && cycles < 20) begin
         tick();
         cycles++;
      end
      if (cycles >= 20) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done_valid=%b, expected 1 within 20 cycles", bus.done_valid);
      end
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.start_ready !== 1'b1) begin
         errors++; $display("FAIL reset_start_ready: got %b, expected 1", bus.start_ready);
      end
      checks++;
      if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_flags: done_valid=%b busy=%b, expected 0 0", bus.done_valid, bus.busy);
      end
      checks++;
      if (bus.sum !== 64'h0 || bus.c_out !== 1'b0) begin
         errors++; $display("FAIL reset_result: sum=%h c_out=%b, expected 0 0", bus.sum, bus.c_out);
      end
      checks++;
      if (bus.slice_a !== 16'h0 || bus.slice_b !== 16'h0 || bus.slice_cin !== 1'b0) begin
         errors++; $display("FAIL reset_slice: a=%h b=%h cin=%b, expected 0 0 0", bus.slice_a, bus.slice_b, bus.slice_cin);
      end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_carry_wrap();
      bus.done_ready = 1'b1;
      accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      for (int k = 1; k < NSLICE; k++) begin
         tick();
         checks++;
         if (bus.done_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_early_done: edge %0d done_valid=%b, expected 0", k, bus.done_valid);
         end
      end
      tick();
      checks++;
      if (bus.done_valid !== 1'b1 || bus.start_ready !== 1'b0) begin
         errors++; $display("FAIL wrap_latency: done_valid=%b start_ready=%b, expected 1 0", bus.done_valid, bus.start_ready);
      end
      checks++;
      if (bus.sum !== 64'h1 || bus.c_out !== 1'b1) begin
         errors++; $display("FAIL wrap_result: sum=%h c_out=%b, expected 0000000000000001 1", bus.sum, bus.c_out);
      end
      tick();
      checks++;
      if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL wrap_return_idle: start_ready=%b done_valid=%b busy=%b, expected 1 0 0",
                            bus.start_ready, bus.done_valid, bus.busy);
      end
      checks++;
      if (bus.sum !== 64'h1) begin
         errors++; $display("FAIL wrap_sum_retained: sum=%h, expected 0000000000000001", bus.sum);
      end
      bus.done_ready = 1'b0;
      $display("test_carry_wrap done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_cross_slice();
      logic exp_cin [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      bus.done_ready = 1'b0;
      accept(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      for (int i = 0; i < NSLICE; i++) begin
         checks++;
         if (bus.slice_cin !== exp_cin[i]) begin
            errors++; $display("FAIL cross_slice_cin: run cycle %0d got %b, expected %b", i, bus.slice_cin, exp_cin[i]);
         end
         tick();
      end
      checks++;
      if (bus.done_valid !== 1'b1 || bus.sum !== 64'h0000_0001_0000_0000 || bus.c_out !== 1'b0) begin
         errors++; $display("FAIL cross_slice_result: done_valid=%b sum=%h c_out=%b, expected 1 0000000100000000 0",
                            bus.done_valid, bus.sum, bus.c_out);
      end
      checks++;
      if (bus.slice_a !== 16'h0 || bus.slice_cin !== 1'b0) begin
         errors++; $display("FAIL cross_slice_idle_bus: slice_a=%h slice_cin=%b, expected 0 0", bus.slice_a, bus.slice_cin);
      end
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      $display("test_cross_slice done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_backpressure();
      bus.done_ready = 1'b0;
      accept(64'd5, 64'd7, 1'b0);
      bus.start_valid = 1'b1;
      bus.a           = 64'd999;
      bus.b           = 64'd1;
      for (int i = 0; i < NSLICE; i++) begin
         checks++;
         if (bus.start_ready !== 1'b0) begin
            errors++; $display("FAIL bp_run_start_ready: run cycle %0d got %b, expected 0", i, bus.start_ready);
         end
         tick();
      end
      bus.start_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.done_valid !== 1'b1 || bus.sum !== 64'd12 || bus.c_out !== 1'b0) begin
            errors++; $display("FAIL bp_stall_hold: stall %0d done_valid=%b sum=%h c_out=%b, expected 1 000000000000000c 0",
                               i, bus.done_valid, bus.sum, bus.c_out);
         end
         tick();
      end
      checks++;
      if (bus.done_valid !== 1'b1 || bus.slice_a !== 16'h0) begin
         errors++; $display("FAIL bp_still_done: done_valid=%b slice_a=%h, expected 1 0", bus.done_valid, bus.slice_a);
      end
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      checks++;
      if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 64'd12) begin
         errors++; $display("FAIL bp_release: done_valid=%b busy=%b sum=%h, expected 0 0 000000000000000c",
                            bus.done_valid, bus.busy, bus.sum);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL bp_no_stray_accept: busy=%b, expected 0", bus.busy);
      end
      $display("test_backpressure done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_op();
      int  cyc;
      logic saw_done;
      bus.done_ready = 1'b1;
      accept(64'h1234, 64'h1, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_flags: busy=%b done_valid=%b start_ready=%b, expected 0 0 1",
                            bus.busy, bus.done_valid, bus.start_ready);
      end
      checks++;
      if (bus.sum !== 64'h0 || bus.c_out !== 1'b0 || bus.slice_a !== 16'h0) begin
         errors++; $display("FAIL midreset_values: sum=%h c_out=%b slice_a=%h, expected 0 0 0",
                            bus.sum, bus.c_out, bus.slice_a);
      end
      tick();
      tick();
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done_valid === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++; $display("FAIL midreset_no_done: saw done_valid=%b, expected 0", saw_done);
      end
      accept(64'd2, 64'd3, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc != NSLICE) begin
         errors++; $display("FAIL midreset_latency: got %0d edges, expected %0d", cyc, NSLICE);
      end
      checks++;
      if (bus.sum !== 64'd5 || bus.c_out !== 1'b0) begin
         errors++; $display("FAIL midreset_after: sum=%h c_out=%b, expected 0000000000000005 0", bus.sum, bus.c_out);
      end
      tick();
      bus.done_ready = 1'b0;
      $display("test_reset_mid_op done: checks=%0d errors=%0d", checks, errors);
   endtask

`ifdef SLICE_ADDER_SUB_EN
   task automatic test_sub();
      int cyc;
      bus.done_ready = 1'b1;
      bus.sub        = 1'b1;
      accept(64'd5, 64'd7, 1'b0);
      wait_done(cyc);
      checks++;
      if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFE || bus.c_out !== 1'b0) begin
         errors++; $display("FAIL sub_borrow: sum=%h c_out=%b, expected fffffffffffffffe 0", bus.sum, bus.c_out);
      end
      tick();
      accept(64'd7, 64'd5, 1'b0);
      wait_done(cyc);
      checks++;
      if (bus.sum !== 64'd2 || bus.c_out !== 1'b1) begin
         errors++; $display("FAIL sub_no_borrow: sum=%h c_out=%b, expected 0000000000000002 1", bus.sum, bus.c_out);
      end
      tick();
      bus.sub        = 1'b0;
      bus.done_ready = 1'b0;
      $display("test_sub done: checks=%0d errors=%0d", checks, errors);
   endtask
`endif

   task automatic test_back_to_back_random();
      logic [WIDTH-1:0] av, bv;
      logic             cv;
      logic [WIDTH:0]   expected;
      int               stall, cyc;
      for (int n = 0; n < 1000; n++) begin
         av       = {$urandom, $urandom};
         bv       = {$urandom, $urandom};
         cv       = 1'($urandom_range(0, 1));
         stall    = $urandom_range(0, 3);
         expected = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
         bus.done_ready = (stall == 0);
         accept(av, bv, cv);
         wait_done(cyc);
         checks++;
         if (cyc != NSLICE) begin
            errors++; $display("FAIL rand_latency: op %0d got %0d edges, expected %0d", n, cyc, NSLICE);
         end
         while (stall > 0) begin
            tick();
            stall--;
         end
         checks++;
         if ({bus.c_out, bus.sum} !== expected) begin
            errors++; $display("FAIL rand_sum: a=%h b=%h c_in=%b got %b_%h, expected %b_%h",
                               av, bv, cv, bus.c_out, bus.sum, expected[WIDTH], expected[WIDTH-1:0]);
         end
         bus.done_ready = 1'b1;
         tick();
      end
      bus.done_ready = 1'b0;
      $display("test_back_to_back_random done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      test_reset();
      test_carry_wrap();
      test_cross_slice();
      test_backpressure();
      test_reset_mid_op();
`ifdef SLICE_ADDER_SUB_EN
      test_sub();
`endif
      test_back_to_back_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/slice_adder_sequencer.md
Name: slice_adder_sequencer

Overview:
- Computes a full WIDTH-bit add by time-multiplexing one external SLICE-bit combinational adder over WIDTH/SLICE cycles, least-significant slice first.
- Captures operands via a valid/ready request handshake, drives the slice adder, and accumulates the sum and ripple carry.
- Presents the result via a valid/ready response handshake.
- Sits between an operand producer and a shared narrow adder, so the wide adder is replaced by a small slice plus this controller.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of SLICE.
SLICE, 16, width of the external adder slice; must be >= 1.
NSLICE, WIDTH/SLICE (localparam), number of RUN cycles per operation.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_valid  in  1  request: operands valid.
start_ready  out  1  request: sequencer can accept.
a  in  WIDTH  operand A, sampled on request handshake.
b  in  WIDTH  operand B, sampled on request handshake.
c_in  in  1  carry-in, sampled on request handshake.
slice_a  out  SLICE  A slice to external adder.
slice_b  out  SLICE  B slice to external adder.
slice_cin  out  1  carry into external adder.
slice_sum  in  SLICE  external adder sum, combinational from slice_*.
slice_cout  in  1  external adder carry-out.
done_valid  out  1  response: sum/c_out valid.
done_ready  in  1  response: consumer accepts.
sum  out  WIDTH  result.
c_out  out  1  final carry-out.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous on rst_n low, release synchronous to clk.
  - State IDLE; a_reg, b_reg, sum, c_out, carry, cnt all 0.
  - done_valid=0, busy=0, start_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1 (combinational from state).
  - On start_valid & start_ready: capture a, b, c_in (carry <= c_in); cnt <= 0; sum <= 0; go RUN.
- RUN:
  - start_ready=0; start_valid is ignored.
  - slice_a = a_reg[cnt*SLICE +: SLICE]; slice_b = b_reg[cnt*SLICE +: SLICE]; slice_cin = carry.
  - Each edge: sum[cnt*SLICE +: SLICE] <= slice_sum; carry <= slice_cout; cnt <= cnt+1.
  - On the edge where cnt==NSLICE-1: c_out <= slice_cout; go DONE.
- Latency: done_valid rises exactly NSLICE edges after the accepting edge (4 with defaults).
- DONE:
  - done_valid=1; sum and c_out held stable until handshake.
  - On done_valid & done_ready: go IDLE; start_ready=1 the following cycle.
  - No same-cycle re-accept; throughput is one operation per NSLICE+2 cycles minimum.
  - done_ready held low stalls indefinitely with outputs frozen.
- Outside RUN: slice_a, slice_b, slice_cin driven 0.
- sum and c_out retain the last result in IDLE until the next accept clears sum.
- Reset mid-RUN or mid-DONE: operation is abandoned, the reset values above apply immediately, and no done_valid is produced for that operation.
- cnt width is clog2(NSLICE), minimum 1. With NSLICE==1, RUN lasts one cycle.
- Arithmetic is unsigned modulo 2^WIDTH; carry out of the top slice goes to c_out.

Optional Feature:
- Macro: SLICE_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the request handshake.
  - sub=1: b_reg <= ~b and carry <= 1 (c_in ignored), giving a-b.
  - c_out=1 means no borrow (a>=b).
- Undefined: port sub absent; add only; behaviour identical to sub=0.

Test Plan:
1. a=64'hFFFF_FFFF_FFFF_FFFF, b=64'd1, c_in=1, done_ready=1 -> done_valid after 4 edges, sum=64'h1, c_out=1; start_ready returns 1 one cycle after the done handshake.
2. a=64'h0000_0000_FFFF_FFFF, b=64'd1, c_in=0 -> cross-slice carry gives sum=64'h0000_0001_0000_0000, c_out=0. Check slice_cin sequence is 0,1,1,0 over the RUN cycles.
3. Backpressure: run a=5, b=7, c_in=0 with done_ready low for 3 cycles after done_valid -> sum=12 stable and done_valid held. Then assert done_ready -> IDLE. start_valid pulsed during RUN is not accepted (start_ready=0).
4. Reset mid-op: accept a=64'h1234, b=64'h1, deassert rst_n in the 2nd RUN cycle -> all outputs go to reset values immediately, no done_valid. A subsequent request a=2, b=3 yields sum=5.
5. SLICE_ADDER_SUB_EN: a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0. Then a=7, b=5, sub=1 -> sum=2, c_out=1.
6. Random: 1000 back-to-back requests with random a, b, c_in and random done_ready stalls -> {c_out,sum} equals a+b+c_in for every response. Check on posedge clk; any mismatch is flagged with a, b, c_in printed.
